reg_xfer_ctrl: RTL

REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

---
 rtl/reg_xfer_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/reg_xfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_xfer_ctrl                                                |
// | Description : Register-to-register block copy controller. Copies len words |
// |               from a register file starting at src to a region starting at |
// |               dst, one word at a time (read, then write). Addresses wrap   |
// |               mod 32. Keeps a mod-256 checksum of the words copied.        |
// | Ports       : clk, rst (async, active-low)                                 |
// |               start/abort/src/dst/len  - transfer control and parameters   |
// |               busy/done/checksum       - transfer status                   |
// |               fr_raddr/fr_rdata        - register-file read port           |
// |               fr_we/fr_waddr/fr_wdata  - register-file write port          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reg_xfer_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] src,
  input  logic [4:0] dst,
  input  logic [5:0] len,
  output logic       busy,
  output logic       done,
  output logic [7:0] checksum,
  output logic [4:0] fr_raddr,
  input  logic [7:0] fr_rdata,
  output logic       fr_we,
  output logic [4:0] fr_waddr,
  output logic [7:0] fr_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0] state_q,    state_d;
  logic [4:0] cur_src_q,  cur_src_d;
  logic [4:0] cur_dst_q,  cur_dst_d;
  logic [5:0] rem_q,      rem_d;
  logic [7:0] buffer_q,   buffer_d;
  logic [7:0] checksum_q, checksum_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cur_src_q  <= 5'd0;
      cur_dst_q  <= 5'd0;
      rem_q      <= 6'd0;
      buffer_q   <= 8'd0;
      checksum_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cur_src_q  <= cur_src_d;
      cur_dst_q  <= cur_dst_d;
      rem_q      <= rem_d;
      buffer_q   <= buffer_d;
      checksum_q <= checksum_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cur_src_d  = cur_src_q;
    cur_dst_d  = cur_dst_q;
    rem_d      = rem_q;
    buffer_d   = buffer_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE: begin
        // abort has no effect here; start alone decides
        if (start) begin
          checksum_d = 8'd0;
          if (len != 6'd0) begin
            cur_src_d = src;
            cur_dst_d = dst;
            rem_d     = len;
            state_d   = S_RD;
          end else begin
            state_d   = S_FIN;
          end
        end
      end
      S_RD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          buffer_d = fr_rdata;
          state_d  = S_WR;
        end
      end
      S_WR: begin
        // An aborted write is not counted: checksum covers completed words only
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          checksum_d = checksum_q + buffer_q;
          cur_src_d  = cur_src_q + 5'd1;
          cur_dst_d  = cur_dst_q + 5'd1;
          rem_d      = rem_q - 6'd1;
          state_d    = (rem_q == 6'd1) ? S_FIN : S_RD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (state_q == S_RD) || (state_q == S_WR);
    done     = (state_q == S_FIN);
    // abort gates the write combinationally in the same cycle
    fr_we    = (state_q == S_WR) && !abort;
    fr_raddr = cur_src_q;
    fr_waddr = cur_dst_q;
    fr_wdata = buffer_q;
    checksum = checksum_q;
  end

endmodule
`default_nettype wire
